// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - op encodings, FSM states and parameter checks for the mul/div unit
// MIPS_MULDIV_MADD_EN adds the ACC state used by MADD/MSUB.
package mips_muldiv_pkg;

   localparam int MD_XLEN_DEFAULT = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MSUB  = 3'd7;

   // Bit k set means k bits per clock is a supported step count.
   localparam logic [7:0] SPC_LEGAL_MASK = 8'b0001_0110;

`ifdef MIPS_MULDIV_MADD_EN
   typedef enum logic [1:0] {IDLE, RUN, FIX, ACC} md_state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;
`endif

   function automatic bit spc_legal(input int xlen, input int spc);
      return (spc > 0) && (spc < 8) &&
             (((SPC_LEGAL_MASK >> spc) & 8'h01) != 8'h00) &&
             ((xlen % spc) == 0);
   endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// rtl/mips_muldiv_step.sv - one combinational shift-add (multiply) or restoring-subtract (divide) bit step
// The {up, low} pair is the partial product, or the remainder and shifting dividend/quotient.
module mips_muldiv_step import mips_muldiv_pkg::*; #(
   parameter int XLEN = MD_XLEN_DEFAULT
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] m,
   input  logic [XLEN-1:0] up_in,
   input  logic [XLEN-1:0] low_in,
   output logic [XLEN-1:0] up_out,
   output logic [XLEN-1:0] low_out
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] sub;
   logic            ge;

   always_comb begin
      sum     = {1'b0, up_in} + (low_in[0] ? {1'b0, m} : '0);
      shifted = {up_in, low_in[XLEN-1]};
      ge      = (shifted >= {1'b0, m});
      // The true difference is below m, so XLEN bits hold it exactly.
      sub     = shifted[XLEN-1:0] - m;
      if (is_div) begin
         up_out  = ge ? sub : shifted[XLEN-1:0];
         low_out = {low_in[XLEN-2:0], ge};
      end else begin
         up_out  = sum[XLEN:1];
         low_out = {sum[0], low_in[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MIPS multiply/divide unit owning HI/LO
// Define MIPS_MULDIV_MADD_EN to enable signed MADD/MSUB accumulate ops.
module mips_muldiv_unit import mips_muldiv_pkg::*; #(
   parameter int XLEN            = MD_XLEN_DEFAULT,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic            kill,
   input  logic            mf_req,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic            stall_req
);

   localparam int N  = XLEN / STEPS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   if (!spc_legal(XLEN, STEPS_PER_CYCLE)) begin : g_bad_spc
      $error("mips_muldiv_unit: STEPS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
   end

   md_state_t       state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] up;
   logic [XLEN-1:0] low;
   logic [XLEN-1:0] mcand;
   logic            is_div;
   logic            neg_q;
   logic            neg_r;
   logic            dz;
`ifdef MIPS_MULDIV_MADD_EN
   logic            acc_op;
   logic            acc_sub;
`endif

   logic            is_md;
   logic            op_signed;
   logic            op_div;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;

   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      op_div    = (op == OP_DIV) || (op == OP_DIVU);
      is_md     = (op <= OP_DIVU);
`ifdef MIPS_MULDIV_MADD_EN
      if ((op == OP_MADD) || (op == OP_MSUB)) begin
         op_signed = 1'b1;
         is_md     = 1'b1;
      end
`endif
      a_neg = op_signed & rs_val[XLEN-1];
      b_neg = op_signed & rt_val[XLEN-1];
      a_mag = a_neg ? -rs_val : rs_val;
      b_mag = b_neg ? -rt_val : rt_val;
   end

   logic [XLEN-1:0] up_c  [STEPS_PER_CYCLE+1];
   logic [XLEN-1:0] low_c [STEPS_PER_CYCLE+1];

   assign up_c[0]  = up;
   assign low_c[0] = low;

   for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
      mips_muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div  (is_div),
         .m       (mcand),
         .up_in   (up_c[g]),
         .low_in  (low_c[g]),
         .up_out  (up_c[g+1]),
         .low_out (low_c[g+1])
      );
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_hi;
   logic [XLEN-1:0]   fix_lo;
   logic              last;

   always_comb begin
      prod_s = neg_q ? -{up, low} : {up, low};
      // Divide by zero leaves the dividend in the remainder, so hi comes out as rs_val.
      quo    = dz ? '1 : (neg_q ? -low : low);
      rem    = neg_r ? -up : up;
      fix_hi = is_div ? rem : prod_s[2*XLEN-1:XLEN];
      fix_lo = is_div ? quo : prod_s[XLEN-1:0];
`ifdef MIPS_MULDIV_MADD_EN
      last   = ((state == FIX) && !acc_op) || (state == ACC);
`else
      last   = (state == FIX);
`endif
   end

   assign busy      = (state != IDLE);
   assign done      = last & ~kill;
   assign div_zero  = done & dz;
   assign stall_req = busy & (mf_req | start);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         up      <= '0;
         low     <= '0;
         mcand   <= '0;
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz      <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef MIPS_MULDIV_MADD_EN
         acc_op  <= 1'b0;
         acc_sub <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start && !kill) begin
                  if (op == OP_MTHI) begin
                     hi <= rs_val;
                  end else if (op == OP_MTLO) begin
                     lo <= rs_val;
                  end else if (is_md) begin
                     up      <= '0;
                     low     <= a_mag;
                     mcand   <= b_mag;
                     is_div  <= op_div;
                     neg_q   <= a_neg ^ b_neg;
                     neg_r   <= a_neg;
                     dz      <= op_div && (rt_val == '0);
`ifdef MIPS_MULDIV_MADD_EN
                     acc_op  <= (op == OP_MADD) || (op == OP_MSUB);
                     acc_sub <= (op == OP_MSUB);
`endif
                     cnt     <= CW'(N - 1);
                     state   <= RUN;
                  end
               end
            end
            RUN: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  up  <= up_c[STEPS_PER_CYCLE];
                  low <= low_c[STEPS_PER_CYCLE];
                  if (cnt == '0) begin
                     state <= FIX;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            FIX: begin
               if (kill) begin
                  state <= IDLE;
`ifdef MIPS_MULDIV_MADD_EN
               end else if (acc_op) begin
                  up    <= prod_s[2*XLEN-1:XLEN];
                  low   <= prod_s[XLEN-1:0];
                  state <= ACC;
`endif
               end else begin
                  hi    <= fix_hi;
                  lo    <= fix_lo;
                  state <= IDLE;
               end
            end
`ifdef MIPS_MULDIV_MADD_EN
            ACC: begin
               if (!kill) begin
                  {hi, lo} <= acc_sub ? ({hi, lo} - {up, low}) : ({hi, lo} + {up, low});
               end
               state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - self-checking bench for mips_muldiv_unit against an arithmetic reference
// Honours MIPS_MULDIV_MADD_EN for the MADD/MSUB expectations.
module tb_mips_muldiv_unit;

   localparam int XLEN = 32;
   localparam int SPC  = 1;
   localparam int N    = XLEN / SPC;
`ifdef MIPS_MULDIV_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [2:0]      op = 3'd0;
   logic [XLEN-1:0] rs_val = '0;
   logic [XLEN-1:0] rt_val = '0;
   logic            kill = 1'b0;
   logic            mf_req = 1'b0;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            busy;
   logic            done;
   logic            div_zero;
   logic            stall_req;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.XLEN(XLEN), .STEPS_PER_CYCLE(SPC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .kill      (kill),
      .mf_req    (mf_req),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .stall_req (stall_req)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result as {div_zero, hi, lo} from plain integer arithmetic.
   function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
      int     sa;
      int     sb;
      longint sp;
      sa = $signed(a);
      sb = $signed(b);
      sp = longint'(sa) * longint'(sb);
      case (o)
         3'd0: return {1'b0, 64'(sp)};
         3'd1: return {1'b0, {32'h0, a} * {32'h0, b}};
         3'd2: begin
            if (b == 32'h0) return {1'b1, a, 32'hffffffff};
            if (a == 32'h80000000 && b == 32'hffffffff) return {1'b0, 32'h0, 32'h80000000};
            return {1'b0, 32'(sa % sb), 32'(sa / sb)};
         end
         3'd3: begin
            if (b == 32'h0) return {1'b1, a, 32'hffffffff};
            return {1'b0, a % b, a / b};
         end
         3'd6: return {1'b0, acc + 64'(sp)};
         3'd7: return {1'b0, acc - 64'(sp)};
         default: return '0;
      endcase
   endfunction

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] r_hi = '0;
   logic [31:0] r_lo = '0;
   logic        r_dz = 1'b0;
   logic        m_pend = 1'b0;
   int          m_cnt = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_pend <= 1'b0;
         m_cnt  <= 0;
      end else if (m_pend) begin
         if (kill) begin
            m_pend <= 1'b0;
         end else if (m_cnt == 1) begin
            m_hi   <= r_hi;
            m_lo   <= r_lo;
            m_pend <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (start && !kill) begin
         if (op == 3'd4) begin
            m_hi <= rs_val;
         end else if (op == 3'd5) begin
            m_lo <= rs_val;
         end else if (op <= 3'd3 || MADD_EN) begin
            m_pend <= 1'b1;
            m_cnt  <= (op >= 3'd6) ? N + 2 : N + 1;
            {r_dz, r_hi, r_lo} <= ref_result(op, rs_val, rt_val, {m_hi, m_lo});
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",      32'(busy),      32'(m_pend));
         chk("done",      32'(done),      32'(m_pend && m_cnt == 1 && !kill));
         chk("div_zero",  32'(div_zero),  32'(m_pend && m_cnt == 1 && !kill && r_dz));
         chk("stall_req", 32'(stall_req), 32'(m_pend && (mf_req || start)));
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int done_cyc, output logic dz_seen);
      @(posedge clk); #1;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      start = 1'b0;
      done_cyc = -1;
      dz_seen  = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (done) begin
            done_cyc = c;
            dz_seen  = div_zero;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] v);
      @(posedge clk); #1;
      start = 1'b1; op = o; rs_val = v;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0: return 32'h0;
         1: return 32'hffffffff;
         2: return 32'h80000000;
         3: return $urandom % 16;
         default: return $urandom;
      endcase
   endfunction

   int   dc;
   logic dz;
   logic saw_done;
   logic busy11;

   initial begin
      #2 rst = 1'b0;
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      @(posedge clk); #1 rst = 1'b1;

      run_op(3'd1, 32'hffffffff, 32'hffffffff, dc, dz);
      chk("multu_latency", 32'(dc), 32'(N + 1));
      chk("multu_hi", hi, 32'hfffffffe);
      chk("multu_lo", lo, 32'h00000001);

      run_op(3'd0, 32'hfffffff9, 32'd3, dc, dz);
      chk("mult_hi", hi, 32'hffffffff);
      chk("mult_lo", lo, 32'hffffffeb);

      run_op(3'd2, 32'hfffffff9, 32'd2, dc, dz);
      chk("div_lo", lo, 32'hfffffffd);
      chk("div_hi", hi, 32'hffffffff);

      run_op(3'd2, 32'h80000000, 32'hffffffff, dc, dz);
      chk("ovf_lo", lo, 32'h80000000);
      chk("ovf_hi", hi, 32'h0);
      chk("ovf_dz", 32'(dz), 32'h0);

      run_op(3'd3, 32'd5, 32'd0, dc, dz);
      chk("dz_lo", lo, 32'hffffffff);
      chk("dz_hi", hi, 32'd5);
      chk("dz_flag", 32'(dz), 32'h1);
      chk("dz_latency", 32'(dc), 32'(N + 1));

      // MFHI/MFLO waiting on a multiply in flight
      @(posedge clk); #1;
      start = 1'b1; op = 3'd0; rs_val = 32'd123456; rt_val = -32'sd789;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 mf_req = 1'b1;
      @(negedge clk);
      chk("mf_stall_c2", 32'(stall_req), 32'h1);
      dc = -1;
      for (int c = 2; c <= 200; c++) begin
         if (done) begin
            dc = c;
            break;
         end
         @(negedge clk);
      end
      chk("mf_done_cyc", 32'(dc), 32'(N + 1));
      chk("mf_stall_done", 32'(stall_req), 32'h1);
      @(negedge clk);
      chk("mf_stall_after", 32'(stall_req), 32'h0);
      chk("mf_hi", hi, 32'hffffffff);
      chk("mf_lo", lo, 32'(-32'sd97406784));
      @(posedge clk); #1 mf_req = 1'b0;

      mt(3'd5, 32'ha5a5a5a5);
      chk("mtlo_lo", lo, 32'ha5a5a5a5);
      chk("mtlo_busy", 32'(busy), 32'h0);
      mt(3'd4, 32'h12345678);
      chk("mthi_hi", hi, 32'h12345678);

      // kill partway through a divide
      @(posedge clk); #1;
      start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
      @(posedge clk); #1 start = 1'b0;
      saw_done = 1'b0;
      busy11 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         if (c == 10) kill = 1'b1;
         @(negedge clk);
         if (done) saw_done = 1'b1;
         if (c == 11) busy11 = busy;
         @(posedge clk); #1 kill = 1'b0;
      end
      chk("kill_busy11", 32'(busy11), 32'h0);
      chk("kill_no_done", 32'(saw_done), 32'h0);
      chk("kill_hi", hi, 32'h12345678);
      chk("kill_lo", lo, 32'ha5a5a5a5);

      mt(3'd4, 32'h0);
      mt(3'd5, 32'd10);
`ifdef MIPS_MULDIV_MADD_EN
      run_op(3'd6, 32'd3, 32'hfffffffc, dc, dz);
      chk("madd_latency", 32'(dc), 32'(N + 2));
      chk("madd_hi", hi, 32'hffffffff);
      chk("madd_lo", lo, 32'hfffffffe);
`else
      @(posedge clk); #1;
      start = 1'b1; op = 3'd6; rs_val = 32'd3; rt_val = 32'hfffffffc;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("madd_off_busy", 32'(busy), 32'h0);
      chk("madd_off_hi", hi, 32'h0);
      chk("madd_off_lo", lo, 32'd10);
`endif

      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #1;
         start  = (($urandom % 3) == 0);
         op     = 3'($urandom % 8);
         rs_val = pick();
         rt_val = pick();
         kill   = (($urandom % 40) == 0);
         mf_req = 1'($urandom % 2);
         if (i == 1500) rst = 1'b0;
         if (i == 1503) rst = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0; mf_req = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
